// File: rtl/pri_encoder_rr_queued_if.sv
// Request/result handshake bundle for pri_encoder_rr_queued: request vector in, encoded index out.
interface pri_encoder_rr_queued_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             enable;
    logic             rr_mode;
    logic [WIDTH-1:0] encoder_in;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] binary_out;
    logic             out_none;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output enable, rr_mode, encoder_in, in_valid, out_ready,
        input  in_ready, binary_out, out_none, out_valid
    );

    modport slave (
        input  enable, rr_mode, encoder_in, in_valid, out_ready,
        output in_ready, binary_out, out_none, out_valid
    );
endinterface

// File: rtl/pri_encoder_rr_queued.sv
// Fixed/round-robin priority encoder feeding a DEPTH-entry result FIFO.
// Define PRI_ENC_RR_EN to build the round-robin pointer; otherwise always lowest-set-bit.
module pri_encoder_rr_queued #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    pri_encoder_rr_queued_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [IDX_W:0]   mem_q [DEPTH];
    logic             full, empty, push, pop;
    logic [IDX_W-1:0] base;
    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;
    logic             found;
    logic [IDX_W-1:0] win_idx;

`ifdef PRI_ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    assign base = bus.rr_mode ? ptr_q : '0;
`else
    logic unused_rr_mode;
    assign unused_rr_mode = bus.rr_mode;
    assign base           = '0;
`endif

    // Rotate so the search start sits at bit 0, take the lowest set bit, then un-rotate.
    always_comb begin
        rot   = WIDTH'({bus.encoder_in, bus.encoder_in} >> base);
        found = |rot;
        off   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum     = {1'b0, base} + {1'b0, off};
        win_idx = (sum >= (IDX_W+1)'(WIDTH)) ? IDX_W'(sum - (IDX_W+1)'(WIDTH)) : IDX_W'(sum);
    end

    assign full           = (count_q == CW'(DEPTH));
    assign empty          = (count_q == '0);
    assign bus.in_ready   = bus.enable && !full;
    assign bus.out_valid  = !empty;
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = bus.out_valid && bus.out_ready;
    assign bus.binary_out = empty ? '0 : mem_q[rd_q][IDX_W-1:0];
    assign bus.out_none   = empty ? 1'b0 : mem_q[rd_q][IDX_W];

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef PRI_ENC_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (push && bus.rr_mode && found)
            ptr_d = (win_idx == IDX_W'(WIDTH - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {!found, found ? win_idx : {IDX_W{1'b0}}};
    end
endmodule

// File: tb/tb_pri_encoder_rr_queued.sv
// Randomized bench for pri_encoder_rr_queued against a queue-based reference model.
module tb_pri_encoder_rr_queued;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(WIDTH);
`ifdef PRI_ENC_RR_EN
    localparam bit RR_BUILT = 1'b1;
`else
    localparam bit RR_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pri_encoder_rr_queued_if #(.WIDTH(WIDTH)) bus ();

    pri_encoder_rr_queued #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             n_cmp = 0;
    int             n_err = 0;
    logic [IDX_W:0] q[$];
    int             mptr = 0;
    int             e_rr[4] = '{0, 4, 15, 0};
    logic           rr_cur = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: scan bits start, start+1, ... modulo WIDTH; first set bit wins.
    function automatic logic [IDX_W:0] model_enc(input logic [WIDTH-1:0] v, input logic rr);
        int start;
        start = (rr && RR_BUILT) ? mptr : 0;
        for (int k = 0; k < WIDTH; k++) begin
            int b;
            b = (start + k) % WIDTH;
            if (v[b]) return {1'b0, IDX_W'(b)};
        end
        return {1'b1, {IDX_W{1'b0}}};
    endfunction

    task automatic check_outputs();
        logic [IDX_W:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        check("out_valid",  bus.out_valid,  q.size() != 0);
        check("in_ready",   bus.in_ready,   bus.enable && (q.size() < DEPTH));
        check("binary_out", bus.binary_out, head[IDX_W-1:0]);
        check("out_none",   bus.out_none,   head[IDX_W]);
    endtask

    // Called with clk low; checks, drives, advances one edge, returns at next negedge.
    task automatic cycle(input logic en, input logic rr, input logic [WIDTH-1:0] vec,
                         input logic iv, input logic ordy);
        logic           push, pop;
        logic [IDX_W:0] enc;
        check_outputs();
        bus.enable     = en;
        bus.rr_mode    = rr;
        bus.encoder_in = vec;
        bus.in_valid   = iv;
        bus.out_ready  = ordy;
        push = iv && en && (q.size() < DEPTH);
        pop  = (q.size() != 0) && ordy;
        enc  = model_enc(vec, rr);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(enc);
            if (rr && RR_BUILT && !enc[IDX_W]) mptr = (int'(enc[IDX_W-1:0]) + 1) % WIDTH;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid",  bus.out_valid,  1'b0);
        check("rst_binary_out", bus.binary_out, '0);
        check("rst_out_none",   bus.out_none,   1'b0);
        q.delete();
        mptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        bus.enable     = 1'b0;
        bus.rr_mode    = 1'b0;
        bus.encoder_in = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid0", bus.out_valid, 1'b0);
        check("rst_ready0", bus.in_ready,  1'b0);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        #1;
        check("rst_ready_en", bus.in_ready, 1'b1);
        @(negedge clk);

        // Fixed priority, lowest set bit
        cycle(1, 0, 16'h8010, 1, 1);
        check("t1_valid", bus.out_valid,  1'b1);
        check("t1_idx",   bus.binary_out, 4);
        check("t1_none",  bus.out_none,   1'b0);
        cycle(1, 0, '0, 0, 1);

        // Round-robin rotation from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 16'h8011, 1, 1);
            check("t3_idx", bus.binary_out, RR_BUILT ? e_rr[i] : 0);
        end

        // Zero vector leaves the pointer alone
        cycle(1, 1, 16'h0000, 1, 1);
        check("t2_none", bus.out_none,   1'b1);
        check("t2_idx",  bus.binary_out, 0);
        cycle(1, 1, 16'h8011, 1, 1);
        check("t2_next", bus.binary_out, RR_BUILT ? 4 : 0);
        cycle(1, 0, '0, 0, 1);

        // Backpressure fills the FIFO, then drains in order
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, WIDTH'($urandom), 1, 0);
        check("t4_full_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, '0, 0, 1);
        check("t4_ready_again", bus.in_ready,  1'b1);
        check("t4_empty",       bus.out_valid, 1'b0);

        // Reset with results queued and pointer advanced
        do_reset();
        cycle(1, 1, 16'h0001, 1, 0);
        cycle(1, 1, 16'h0004, 1, 0);
        cycle(1, 1, 16'h0010, 1, 0);
        check("t5_queued", bus.out_valid, 1'b1);
        do_reset();
        cycle(1, 1, 16'h8011, 1, 1);
        check("t5_after", bus.binary_out, 0);
        cycle(1, 0, '0, 0, 1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                2:       v = WIDTH'($urandom);
                default: v = WIDTH'($urandom & $urandom);
            endcase
            if ($urandom_range(0, 15) == 0) rr_cur = ~rr_cur;
            cycle($urandom_range(0, 9) != 0, rr_cur, v,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, rr_cur, '0, 0, 1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
